layer_tile_scheduler: RTL and testbench
=======================================

// Module: layer_tile_scheduler
// PURPOSE
//  Sequences one conv layer as a series of OFM-channel tiles of TOTAL_PE channels each.
//  Per tile it drives three phases: the load/compute control unit's LOAD, CAL and STORE.
//  Generates per-tile weight/OFM base addresses and the valid channel count.
//  Sits between the host run/start logic and the load, compute and store engines.
// PARAMETERS
//  TOTAL_PE   16            PE count = output channels per tile
//  ADDR_W     32            width of byte addresses
//  OFM_BASE   32'h0000_0000 byte base address of the OFM region
// PORTS
//  clk               in   1       clock
//  rst_n             in   1       async active-low reset
//  start             in   1       1-cycle pulse; starts a layer (honoured in IDLE only)
//  abort             in   1       synchronous abort; returns to IDLE
//  KERNEL_W          in   4       kernel width
//  IFM_C             in   8       input channels
//  OFM_W             in   8       output width (square OFM)
//  OFM_C             in   8       output channels
//  load_req          out  1       level; request weight (+IFM) load for current tile
//  load_ifm          out  1       qualifies load_req; IFM is loaded on tile 0 only
//  load_done         in   1       1-cycle pulse from loader
//  cal_start         out  1       level; compute current tile
//  done_compute      in   1       1-cycle pulse from compute array
//  store_req         out  1       level; write current tile's OFM
//  store_done        in   1       1-cycle pulse from store engine
//  tile_idx          out  8       current tile index
//  tile_ch           out  5       valid channels in tile, 1..TOTAL_PE
//  weight_base_addr  out  ADDR_W  byte address of the tile's weights
//  ofm_base_addr     out  ADDR_W  byte address of the tile's OFM
//  busy              out  1       high in every state except IDLE
//  layer_done        out  1       1-cycle pulse when layer completes
//  state_o           out  3       current state, debug
// BEHAVIOUR
//  Reset values: state IDLE; all outputs 0, except ofm_base_addr = OFM_BASE.
//  States: IDLE=0, CFG=1, LOAD=2, CAL=3, STORE=4, NEXT=5, DONE=6. Outputs are decoded from registered state.
//  IDLE: on start, latch KERNEL_W/IFM_C/OFM_W/OFM_C and go to CFG.
//    Config inputs are ignored at all other times, so later changes do not affect a running layer.
//  CFG, one cycle:
//    num_tiles    = ceil(OFM_C/TOTAL_PE)
//    w_tile_bytes = IFM_C*KERNEL_W^2*TOTAL_PE
//    o_tile_bytes = OFM_W^2*TOTAL_PE
//    Both byte counts are zero-extended to ADDR_W; no saturation.
//    Clear tile_idx and weight_base_addr; set ofm_base_addr = OFM_BASE.
//    If OFM_C==0 go to DONE (no requests issued); otherwise go to LOAD.
//  LOAD: load_req=1, and load_ifm=1 when tile_idx==0. On load_done go to CAL.
//  CAL: cal_start=1. On done_compute go to STORE.
//  STORE: store_req=1. On store_done go to NEXT.
//  NEXT, one cycle:
//    if tile_idx==num_tiles-1, go to DONE;
//    else tile_idx+1, weight_base_addr += w_tile_bytes, ofm_base_addr += o_tile_bytes, go to LOAD.
//  DONE: layer_done=1 for one cycle, then IDLE.
//  tile_ch = min(TOTAL_PE, OFM_C - tile_idx*TOTAL_PE). It is stable from CFG exit until the next NEXT.
//  Start-to-first request latency: start at edge N -> load_req high after edge N+2.
//  Done pulses that arrive outside their own state are ignored (e.g. load_done during CAL).
//  Each request drops the cycle after its done pulse is sampled; no request is ever asserted in IDLE.
//  abort has priority over every transition, including a same-cycle done pulse.
//    Next state is IDLE; outputs clear as at reset, layer_done is not pulsed.
//  start while busy is ignored. start together with abort in IDLE: abort wins, stay in IDLE.
//  rst_n is asserted asynchronously mid-layer: immediate return to the reset values.
// TESTING
//  TOTAL_PE=16, OFM_C=32, IFM_C=8, K=3, OFM_W=10:
//    two tiles, load_ifm only on tile 0; weight_base 0 then 1152; ofm_base 0 then 1600; one layer_done.
//  OFM_C=20: tile_ch=16 on tile 0 and 4 on tile 1; num_tiles=2.
//  OFM_C=0: start -> CFG -> DONE; layer_done 2 cycles after start; load_req never asserted.
//  abort asserted in CAL in the same cycle as done_compute:
//    next state IDLE, cal_start=0, no store_req, no layer_done.
//  Stray store_done during LOAD, and start pulsed during CAL: both have no effect; sequence completes normally.
//  rst_n pulled low during STORE: store_req=0 and state_o=0 immediately; a new start runs the layer cleanly.

Source files
------------

// File: rtl/layer_tile_scheduler.sv
// Purpose : sequences one conv layer as OFM-channel tiles of TOTAL_PE channels, driving LOAD/CAL/STORE per tile.
// Latency : start sampled -> CFG next cycle -> load_req the cycle after; one NEXT cycle between tiles.
// Backpressure: each phase waits indefinitely for its done pulse; abort (sync) or rst_n (async) return to IDLE.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   start, abort                      layer start pulse (IDLE only), synchronous abort (highest priority)
//   KERNEL_W, IFM_C, OFM_W, OFM_C     layer configuration, latched on start
//   load_req/load_ifm/load_done       loader handshake; load_ifm qualifies load_req on tile 0
//   cal_start/done_compute            compute handshake
//   store_req/store_done              store handshake
//   tile_idx, tile_ch                 current tile index and its valid channel count
//   weight_base_addr, ofm_base_addr   per-tile byte base addresses
//   busy, layer_done, state_o         status: not-IDLE level, completion pulse, debug state
module layer_tile_scheduler #(
    parameter int                TOTAL_PE = 16,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] OFM_BASE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        KERNEL_W,
    input  logic [7:0]        IFM_C,
    input  logic [7:0]        OFM_W,
    input  logic [7:0]        OFM_C,
    output logic              load_req,
    output logic              load_ifm,
    input  logic              load_done,
    output logic              cal_start,
    input  logic              done_compute,
    output logic              store_req,
    input  logic              store_done,
    output logic [7:0]        tile_idx,
    output logic [4:0]        tile_ch,
    output logic [ADDR_W-1:0] weight_base_addr,
    output logic [ADDR_W-1:0] ofm_base_addr,
    output logic              busy,
    output logic              layer_done,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CAL   = 3'd3,
        ST_STORE = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          kernel_w_q, kernel_w_d;
    logic [7:0]          ifm_c_q, ifm_c_d;
    logic [7:0]          ofm_w_q, ofm_w_d;
    logic [7:0]          ofm_c_q, ofm_c_d;
    logic [7:0]          num_tiles_q, num_tiles_d;
    logic [ADDR_W-1:0]   w_tile_bytes_q, w_tile_bytes_d;
    logic [ADDR_W-1:0]   o_tile_bytes_q, o_tile_bytes_d;
    logic [7:0]          tile_idx_q, tile_idx_d;
    logic [4:0]          tile_ch_q, tile_ch_d;
    logic [ADDR_W-1:0]   weight_base_q, weight_base_d;
    logic [ADDR_W-1:0]   ofm_base_q, ofm_base_d;

    // Channels remaining for tile idx, clamped to the PE count.
    function automatic logic [4:0] calc_tile_ch(input logic [7:0] ofm_c, input logic [7:0] idx);
        logic [15:0] used;
        logic [15:0] rem;
        used = 16'(idx) * 16'(TOTAL_PE);
        rem  = 16'(ofm_c) - used;
        if (rem >= 16'(TOTAL_PE)) begin
            return 5'(TOTAL_PE);
        end
        return rem[4:0];
    endfunction

    always_comb begin
        state_d        = state_q;
        kernel_w_d     = kernel_w_q;
        ifm_c_d        = ifm_c_q;
        ofm_w_d        = ofm_w_q;
        ofm_c_d        = ofm_c_q;
        num_tiles_d    = num_tiles_q;
        w_tile_bytes_d = w_tile_bytes_q;
        o_tile_bytes_d = o_tile_bytes_q;
        tile_idx_d     = tile_idx_q;
        tile_ch_d      = tile_ch_q;
        weight_base_d  = weight_base_q;
        ofm_base_d     = ofm_base_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    kernel_w_d = KERNEL_W;
                    ifm_c_d    = IFM_C;
                    ofm_w_d    = OFM_W;
                    ofm_c_d    = OFM_C;
                    state_d    = ST_CFG;
                end
            end
            ST_CFG: begin
                num_tiles_d    = 8'((16'(ofm_c_q) + 16'(TOTAL_PE - 1)) / 16'(TOTAL_PE));
                w_tile_bytes_d = ADDR_W'(ifm_c_q) * ADDR_W'(kernel_w_q) * ADDR_W'(kernel_w_q)
                                 * ADDR_W'(TOTAL_PE);
                o_tile_bytes_d = ADDR_W'(ofm_w_q) * ADDR_W'(ofm_w_q) * ADDR_W'(TOTAL_PE);
                tile_idx_d     = 8'd0;
                tile_ch_d      = calc_tile_ch(ofm_c_q, 8'd0);
                weight_base_d  = '0;
                ofm_base_d     = OFM_BASE;
                // An empty layer completes without touching any engine.
                state_d        = (ofm_c_q == 8'd0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                if (load_done) state_d = ST_CAL;
            end
            ST_CAL: begin
                if (done_compute) state_d = ST_STORE;
            end
            ST_STORE: begin
                if (store_done) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (tile_idx_q == num_tiles_q - 8'd1) begin
                    state_d = ST_DONE;
                end else begin
                    tile_idx_d    = tile_idx_q + 8'd1;
                    tile_ch_d     = calc_tile_ch(ofm_c_q, tile_idx_q + 8'd1);
                    weight_base_d = weight_base_q + w_tile_bytes_q;
                    ofm_base_d    = ofm_base_q + o_tile_bytes_q;
                    state_d       = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every transition, including a done pulse in the same cycle,
        // and restores the reset-time view of all outputs.
        if (abort) begin
            state_d        = ST_IDLE;
            kernel_w_d     = '0;
            ifm_c_d        = '0;
            ofm_w_d        = '0;
            ofm_c_d        = '0;
            num_tiles_d    = '0;
            w_tile_bytes_d = '0;
            o_tile_bytes_d = '0;
            tile_idx_d     = '0;
            tile_ch_d      = '0;
            weight_base_d  = '0;
            ofm_base_d     = OFM_BASE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            kernel_w_q     <= '0;
            ifm_c_q        <= '0;
            ofm_w_q        <= '0;
            ofm_c_q        <= '0;
            num_tiles_q    <= '0;
            w_tile_bytes_q <= '0;
            o_tile_bytes_q <= '0;
            tile_idx_q     <= '0;
            tile_ch_q      <= '0;
            weight_base_q  <= '0;
            ofm_base_q     <= OFM_BASE;
        end else begin
            state_q        <= state_d;
            kernel_w_q     <= kernel_w_d;
            ifm_c_q        <= ifm_c_d;
            ofm_w_q        <= ofm_w_d;
            ofm_c_q        <= ofm_c_d;
            num_tiles_q    <= num_tiles_d;
            w_tile_bytes_q <= w_tile_bytes_d;
            o_tile_bytes_q <= o_tile_bytes_d;
            tile_idx_q     <= tile_idx_d;
            tile_ch_q      <= tile_ch_d;
            weight_base_q  <= weight_base_d;
            ofm_base_q     <= ofm_base_d;
        end
    end

    // All control outputs decode the registered state, so they are glitch-free
    // and drop the cycle after the matching done pulse is sampled.
    assign load_req         = (state_q == ST_LOAD);
    assign load_ifm         = (state_q == ST_LOAD) && (tile_idx_q == 8'd0);
    assign cal_start        = (state_q == ST_CAL);
    assign store_req        = (state_q == ST_STORE);
    assign busy             = (state_q != ST_IDLE);
    assign layer_done       = (state_q == ST_DONE);
    assign state_o          = state_q;
    assign tile_idx         = tile_idx_q;
    assign tile_ch          = tile_ch_q;
    assign weight_base_addr = weight_base_q;
    assign ofm_base_addr    = ofm_base_q;

endmodule

// File: tb/tb_layer_tile_scheduler.sv
// Purpose : directed self-checking bench for layer_tile_scheduler.
// Latency : inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: done pulses are driven by the bench at known cycles; a watchdog bounds the run.
module tb_layer_tile_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  KERNEL_W;
    logic [7:0]  IFM_C;
    logic [7:0]  OFM_W;
    logic [7:0]  OFM_C;
    logic        load_req;
    logic        load_ifm;
    logic        load_done;
    logic        cal_start;
    logic        done_compute;
    logic        store_req;
    logic        store_done;
    logic [7:0]  tile_idx;
    logic [4:0]  tile_ch;
    logic [31:0] weight_base_addr;
    logic [31:0] ofm_base_addr;
    logic        busy;
    logic        layer_done;
    logic [2:0]  state_o;

    int total;
    int bad;

    layer_tile_scheduler #(
        .TOTAL_PE (16),
        .ADDR_W   (32),
        .OFM_BASE (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .KERNEL_W         (KERNEL_W),
        .IFM_C            (IFM_C),
        .OFM_W            (OFM_W),
        .OFM_C            (OFM_C),
        .load_req         (load_req),
        .load_ifm         (load_ifm),
        .load_done        (load_done),
        .cal_start        (cal_start),
        .done_compute     (done_compute),
        .store_req        (store_req),
        .store_done       (store_done),
        .tile_idx         (tile_idx),
        .tile_ch          (tile_ch),
        .weight_base_addr (weight_base_addr),
        .ofm_base_addr    (ofm_base_addr),
        .busy             (busy),
        .layer_done       (layer_done),
        .state_o          (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask
    task automatic pulse_load();
        load_done = 1'b1; tick(); load_done = 1'b0;
    endtask
    task automatic pulse_cal();
        done_compute = 1'b1; tick(); done_compute = 1'b0;
    endtask
    task automatic pulse_store();
        store_done = 1'b1; tick(); store_done = 1'b0;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        load_done    = 1'b0;
        done_compute = 1'b0;
        store_done   = 1'b0;
        KERNEL_W     = 4'd0;
        IFM_C        = 8'd0;
        OFM_W        = 8'd0;
        OFM_C        = 8'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load_req", 32'(load_req), 32'd0);
        chk("rst_ofm_base", ofm_base_addr, 32'd0);
        chk("rst_tile_ch", 32'(tile_ch), 32'd0);
        rst_n = 1'b1;
        tick();

        // Layer A: OFM_C=32, IFM_C=8, K=3, OFM_W=10 -> 2 tiles, w=1152, o=1600
        KERNEL_W = 4'd3; IFM_C = 8'd8; OFM_W = 8'd10; OFM_C = 8'd32;
        pulse_start();
        chk("a_cfg_state", 32'(state_o), 32'd1);
        chk("a_cfg_busy", 32'(busy), 32'd1);
        chk("a_cfg_no_load", 32'(load_req), 32'd0);
        tick();
        chk("a_t0_state", 32'(state_o), 32'd2);
        chk("a_t0_load_req", 32'(load_req), 32'd1);
        chk("a_t0_load_ifm", 32'(load_ifm), 32'd1);
        chk("a_t0_idx", 32'(tile_idx), 32'd0);
        chk("a_t0_ch", 32'(tile_ch), 32'd16);
        chk("a_t0_wbase", weight_base_addr, 32'd0);
        chk("a_t0_obase", ofm_base_addr, 32'd0);
        pulse_store();  // stray, ignored in LOAD
        chk("a_stray_store", 32'(state_o), 32'd2);
        pulse_load();
        chk("a_t0_cal_state", 32'(state_o), 32'd3);
        chk("a_t0_load_drop", 32'(load_req), 32'd0);
        chk("a_t0_cal_start", 32'(cal_start), 32'd1);
        pulse_start();  // ignored while busy
        chk("a_start_in_cal", 32'(state_o), 32'd3);
        pulse_cal();
        chk("a_t0_store_state", 32'(state_o), 32'd4);
        chk("a_t0_store_req", 32'(store_req), 32'd1);
        chk("a_t0_cal_drop", 32'(cal_start), 32'd0);
        pulse_store();
        chk("a_t0_next", 32'(state_o), 32'd5);
        chk("a_t0_store_drop", 32'(store_req), 32'd0);
        tick();
        chk("a_t1_state", 32'(state_o), 32'd2);
        chk("a_t1_idx", 32'(tile_idx), 32'd1);
        chk("a_t1_load_ifm", 32'(load_ifm), 32'd0);
        chk("a_t1_ch", 32'(tile_ch), 32'd16);
        chk("a_t1_wbase", weight_base_addr, 32'd1152);
        chk("a_t1_obase", ofm_base_addr, 32'd1600);
        pulse_load();
        pulse_cal();
        pulse_store();
        tick();
        chk("a_done_state", 32'(state_o), 32'd6);
        chk("a_layer_done", 32'(layer_done), 32'd1);
        tick();
        chk("a_idle_state", 32'(state_o), 32'd0);
        chk("a_layer_done_drop", 32'(layer_done), 32'd0);
        chk("a_idle_busy", 32'(busy), 32'd0);

        // Layer B: OFM_C=20, IFM_C=4, K=1, OFM_W=4 -> w=64, o=256; config changed after start
        KERNEL_W = 4'd1; IFM_C = 8'd4; OFM_W = 8'd4; OFM_C = 8'd20;
        pulse_start();
        OFM_C = 8'd0; IFM_C = 8'd99;
        tick();
        chk("b_t0_ch", 32'(tile_ch), 32'd16);
        chk("b_t0_state", 32'(state_o), 32'd2);
        pulse_load();
        pulse_cal();
        pulse_store();
        tick();
        chk("b_t1_idx", 32'(tile_idx), 32'd1);
        chk("b_t1_ch", 32'(tile_ch), 32'd4);
        chk("b_t1_wbase", weight_base_addr, 32'd64);
        chk("b_t1_obase", ofm_base_addr, 32'd256);
        pulse_load();
        pulse_cal();
        pulse_store();
        tick();
        chk("b_done", 32'(layer_done), 32'd1);
        tick();

        // Layer C: OFM_C=0 -> CFG -> DONE, no load request
        OFM_C = 8'd0;
        pulse_start();
        chk("c_cfg", 32'(state_o), 32'd1);
        tick();
        chk("c_done_state", 32'(state_o), 32'd6);
        chk("c_layer_done", 32'(layer_done), 32'd1);
        chk("c_no_load", 32'(load_req), 32'd0);
        tick();
        chk("c_idle", 32'(state_o), 32'd0);

        // start with abort in IDLE: abort wins
        OFM_C = 8'd16; IFM_C = 8'd2; KERNEL_W = 4'd3; OFM_W = 8'd8;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("d_start_abort_idle", 32'(state_o), 32'd0);

        // Abort in CAL together with done_compute
        pulse_start();
        tick();
        pulse_load();
        chk("e_in_cal", 32'(state_o), 32'd3);
        abort = 1'b1; done_compute = 1'b1;
        tick();
        abort = 1'b0; done_compute = 1'b0;
        chk("e_abort_state", 32'(state_o), 32'd0);
        chk("e_abort_cal", 32'(cal_start), 32'd0);
        chk("e_abort_store", 32'(store_req), 32'd0);
        chk("e_abort_done", 32'(layer_done), 32'd0);
        chk("e_abort_ch", 32'(tile_ch), 32'd0);
        tick();
        chk("e_after_store", 32'(store_req), 32'd0);
        chk("e_after_done", 32'(layer_done), 32'd0);

        // Async reset during STORE, then a clean rerun of layer A
        KERNEL_W = 4'd3; IFM_C = 8'd8; OFM_W = 8'd10; OFM_C = 8'd32;
        pulse_start();
        tick();
        pulse_load();
        pulse_cal();
        chk("f_in_store", 32'(store_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("f_rst_store_req", 32'(store_req), 32'd0);
        chk("f_rst_state", 32'(state_o), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        pulse_start();
        tick();
        chk("f_rerun_state", 32'(state_o), 32'd2);
        chk("f_rerun_ifm", 32'(load_ifm), 32'd1);
        chk("f_rerun_wbase", weight_base_addr, 32'd0);
        pulse_load();
        pulse_cal();
        pulse_store();
        tick();
        chk("f_rerun_t1_obase", ofm_base_addr, 32'd1600);
        pulse_load();
        pulse_cal();
        pulse_store();
        tick();
        chk("f_rerun_done", 32'(layer_done), 32'd1);
        tick();
        chk("f_rerun_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
